bouncing_sprite_engine: RTL and testbench

//  Parametrised sprite overlay for the VGA path. Reads a SPRITE_W x SPRITE_H 8-bit grey sprite from

---
 rtl/vga_pkg.sv | 15 +
 rtl/sprite_motion.sv | 116 +++++++++++
 rtl/bouncing_sprite_engine.sv | 135 +++++++++++++
 tb/tb_bouncing_sprite_engine.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA overlay types: sprite motion states, default raster size, grey pixel type.
package vga_pkg;

  typedef enum logic {FROZEN, MOVING} sprite_state_t;

  localparam int unsigned H_RES_DEF = 640;
  localparam int unsigned V_RES_DEF = 480;

  // Widths of the timing generator's x/y buses.
  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  typedef logic [7:0] grey_t;

endpackage

// File: rtl/sprite_motion.sv
// Sprite position keeper: FROZEN/MOVING FSM, frame divider and edge-bounce arithmetic.
module sprite_motion
  import vga_pkg::*;
#(
  parameter int unsigned H_RES     = H_RES_DEF,
  parameter int unsigned V_RES     = V_RES_DEF,
  parameter int unsigned SPRITE_W  = 200,
  parameter int unsigned SPRITE_H  = 230,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned INIT_X    = 50,
  parameter int unsigned INIT_Y    = 50
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick_i,
  input  logic           move_en_i,
  output logic [X_W-1:0] pos_x_o,
  output logic [Y_W-1:0] pos_y_o
);

  localparam int unsigned SXW   = X_W + 2;
  localparam int unsigned SYW   = Y_W + 2;
  localparam int unsigned CNT_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic signed [SXW-1:0] STEP_X  = SXW'(STEP);
  localparam logic signed [SXW-1:0] H_RES_S = SXW'(H_RES);
  localparam logic signed [SXW-1:0] SPR_W_S = SXW'(SPRITE_W);
  localparam logic signed [SYW-1:0] STEP_Y  = SYW'(STEP);
  localparam logic signed [SYW-1:0] V_RES_S = SYW'(V_RES);
  localparam logic signed [SYW-1:0] SPR_H_S = SYW'(SPRITE_H);
  localparam logic [X_W-1:0]        X_MAX   = X_W'(H_RES - SPRITE_W);
  localparam logic [Y_W-1:0]        Y_MAX   = Y_W'(V_RES - SPRITE_H);

  sprite_state_t         state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [X_W-1:0]        pos_x_q, pos_x_d;
  logic [Y_W-1:0]        pos_y_q, pos_y_d;
  logic                  dir_x_neg_q, dir_x_neg_d;
  logic                  dir_y_neg_q, dir_y_neg_d;
  logic signed [SXW-1:0] nx_c;
  logic signed [SYW-1:0] ny_c;
  logic                  adv_c;
  logic                  cnt_wrap_c;

  // Bounced X candidate; the far wall takes priority over the near wall.
  always_comb begin : x_bounce
    nx_c        = $signed({2'b00, pos_x_q}) + (dir_x_neg_q ? -STEP_X : STEP_X);
    pos_x_d     = X_W'(nx_c);
    dir_x_neg_d = dir_x_neg_q;
    if (nx_c + SPR_W_S > H_RES_S) begin
      pos_x_d     = X_MAX;
      dir_x_neg_d = 1'b1;
    end else if (nx_c[SXW-1]) begin
      pos_x_d     = '0;
      dir_x_neg_d = 1'b0;
    end
  end

  always_comb begin : y_bounce
    ny_c        = $signed({2'b00, pos_y_q}) + (dir_y_neg_q ? -STEP_Y : STEP_Y);
    pos_y_d     = Y_W'(ny_c);
    dir_y_neg_d = dir_y_neg_q;
    if (ny_c + SPR_H_S > V_RES_S) begin
      pos_y_d     = Y_MAX;
      dir_y_neg_d = 1'b1;
    end else if (ny_c[SYW-1]) begin
      pos_y_d     = '0;
      dir_y_neg_d = 1'b0;
    end
  end

  // A tick with move_en set lands in MOVING, so the entering tick already counts.
  always_comb begin : advance
    adv_c      = frame_tick_i && move_en_i;
    cnt_wrap_c = (cnt_q == CNT_W'(FRAME_DIV - 1));
  end

  always_ff @(posedge clk) begin : fsm
    if (rst) begin
      state_q <= FROZEN;
    end else if (frame_tick_i) begin
      case (state_q)
        FROZEN:  if (move_en_i)  state_q <= MOVING;
        MOVING:  if (!move_en_i) state_q <= FROZEN;
        default: state_q <= FROZEN;
      endcase
    end
  end

  always_ff @(posedge clk) begin : motion
    if (rst) begin
      cnt_q       <= '0;
      pos_x_q     <= X_W'(INIT_X);
      pos_y_q     <= Y_W'(INIT_Y);
      dir_x_neg_q <= 1'b0;
      dir_y_neg_q <= 1'b0;
    end else if (adv_c) begin
      if (cnt_wrap_c) begin
        cnt_q       <= '0;
        pos_x_q     <= pos_x_d;
        pos_y_q     <= pos_y_d;
        dir_x_neg_q <= dir_x_neg_d;
        dir_y_neg_q <= dir_y_neg_d;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end else if (frame_tick_i) begin
      cnt_q <= '0;
    end
  end

  assign pos_x_o = pos_x_q;
  assign pos_y_o = pos_y_q;

endmodule

// File: rtl/bouncing_sprite_engine.sv
// Sprite overlay between VGA timing and DAC: hit test, VRAM addressing, 3-clk colour pipeline.
module bouncing_sprite_engine
  import vga_pkg::*;
#(
  parameter int unsigned H_RES     = H_RES_DEF,
  parameter int unsigned V_RES     = V_RES_DEF,
  parameter int unsigned SPRITE_W  = 200,
  parameter int unsigned SPRITE_H  = 230,
  parameter int unsigned ADDR_W    = 18,
  parameter int unsigned STEP      = 1,
  parameter int unsigned FRAME_DIV = 1,
  parameter int unsigned INIT_X    = 50,
  parameter int unsigned INIT_Y    = 50,
  parameter grey_t       KEY       = 8'h00,
  parameter grey_t       BG        = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              display_enabled,
  input  logic [X_W-1:0]    x,
  input  logic [Y_W-1:0]    y,
  input  logic              move_en,
  input  logic              key_en,
  input  logic [7:0]        vram_data,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_tick
);

  logic [X_W-1:0]    pos_x;
  logic [Y_W-1:0]    pos_y;

  logic              hit_c;
  logic              tick_c;
  logic [X_W-1:0]    dx_c;
  logic [Y_W-1:0]    dy_c;
  logic [ADDR_W-1:0] addr_c;
  grey_t             pix_c;

  logic [ADDR_W-1:0] vram_addr_q;
  logic              frame_tick_q;
  logic              hit_q1, act_q1, key_q1;
  logic              hit_q2, act_q2, key_q2;
  grey_t             pix_q;

  sprite_motion #(
    .H_RES     (H_RES),
    .V_RES     (V_RES),
    .SPRITE_W  (SPRITE_W),
    .SPRITE_H  (SPRITE_H),
    .STEP      (STEP),
    .FRAME_DIV (FRAME_DIV),
    .INIT_X    (INIT_X),
    .INIT_Y    (INIT_Y)
  ) u_motion (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick_q),
    .move_en_i    (move_en),
    .pos_x_o      (pos_x),
    .pos_y_o      (pos_y)
  );

  // Inclusive hit window, compared one bit wider so pos+size cannot wrap.
  always_comb begin : hit_test
    hit_c = (x >= pos_x) && ({1'b0, x} < ({1'b0, pos_x} + (X_W+1)'(SPRITE_W))) &&
            (y >= pos_y) && ({1'b0, y} < ({1'b0, pos_y} + (Y_W+1)'(SPRITE_H)));
    dx_c   = x - pos_x;
    dy_c   = y - pos_y;
    addr_c = '0;
    if (hit_c) begin
      addr_c = ADDR_W'(dy_c) * ADDR_W'(SPRITE_W) + ADDR_W'(dx_c);
    end
    tick_c = display_enabled && (x == X_W'(H_RES - 1)) && (y == Y_W'(V_RES - 1));
  end

  always_ff @(posedge clk) begin : stage1
    if (rst) begin
      vram_addr_q  <= '0;
      frame_tick_q <= 1'b0;
      hit_q1       <= 1'b0;
      act_q1       <= 1'b0;
      key_q1       <= 1'b0;
    end else begin
      vram_addr_q  <= addr_c;
      frame_tick_q <= tick_c;
      hit_q1       <= hit_c;
      act_q1       <= display_enabled;
      key_q1       <= key_en;
    end
  end

  // Flags wait here while the VRAM read is in flight.
  always_ff @(posedge clk) begin : stage2
    if (rst) begin
      hit_q2 <= 1'b0;
      act_q2 <= 1'b0;
      key_q2 <= 1'b0;
    end else begin
      hit_q2 <= hit_q1;
      act_q2 <= act_q1;
      key_q2 <= key_q1;
    end
  end

  always_comb begin : colour_mux
    pix_c = '0;
    if (!act_q2) begin
      pix_c = '0;
    end else if (!hit_q2) begin
      pix_c = BG;
    end else if (key_q2 && (vram_data == KEY)) begin
      pix_c = BG;
    end else begin
      pix_c = vram_data;
    end
  end

  always_ff @(posedge clk) begin : stage3
    if (rst) begin
      pix_q <= '0;
    end else begin
      pix_q <= pix_c;
    end
  end

  assign vram_addr  = vram_addr_q;
  assign frame_tick = frame_tick_q;
  assign r          = pix_q;
  assign g          = pix_q;
  assign b          = pix_q;

endmodule

// File: tb/tb_bouncing_sprite_engine.sv
// Scoreboard bench for bouncing_sprite_engine: default instance for pixels, two small ones for bounces.
module tb_bouncing_sprite_engine;
  import vga_pkg::*;

  typedef struct {
    int          due;
    int          id;
    logic        ca;
    logic [17:0] addr;
    logic        tick;
    logic [7:0]  rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        display_enabled;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        key_en;
  logic        move_en_a, move_en_4, move_en_5;
  logic [7:0]  vram_data_a;
  logic [17:0] addr_a, addr_4, addr_5;
  logic [7:0]  r_a, g_a, b_a, r_4, g_4, b_4, r_5, g_5, b_5;
  logic        tick_a, tick_4, tick_5;

  int   cyc = 0;
  int   vec_id = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q1[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bouncing_sprite_engine dut (
    .clk(clk), .rst(rst), .display_enabled(display_enabled), .x(x), .y(y),
    .move_en(move_en_a), .key_en(key_en), .vram_data(vram_data_a),
    .vram_addr(addr_a), .r(r_a), .g(g_a), .b(b_a), .frame_tick(tick_a)
  );

  bouncing_sprite_engine #(.INIT_X(438), .STEP(4)) dut4 (
    .clk(clk), .rst(rst), .display_enabled(display_enabled), .x(x), .y(y),
    .move_en(move_en_4), .key_en(key_en), .vram_data(vram_data_a),
    .vram_addr(addr_4), .r(r_4), .g(g_4), .b(b_4), .frame_tick(tick_4)
  );

  bouncing_sprite_engine #(.H_RES(8), .V_RES(6), .SPRITE_W(4), .SPRITE_H(2),
                           .INIT_X(0), .INIT_Y(0)) dut5 (
    .clk(clk), .rst(rst), .display_enabled(display_enabled), .x(x), .y(y),
    .move_en(move_en_5), .key_en(key_en), .vram_data(vram_data_a),
    .vram_addr(addr_5), .r(r_5), .g(g_5), .b(b_5), .frame_tick(tick_5)
  );

  // VRAM contents: a fixed pattern with two hand-placed words for the key tests.
  function automatic logic [7:0] vram_fn(input logic [17:0] a);
    if (a == 18'd1000) return 8'h00;
    if (a == 18'd1001) return 8'hA5;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) vram_data_a <= vram_fn(addr_a);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations when their cycle arrives.
  always @(negedge clk) begin
    exp_t e;
    if (q1.size() != 0 && q1[0].due <= cyc) begin
      e = q1.pop_front();
      chk($sformatf("stage1_due#%0d", e.id), 32'(e.due), 32'(cyc));
      if (e.ca) chk($sformatf("vram_addr#%0d", e.id), 32'(addr_a), 32'(e.addr));
      chk($sformatf("frame_tick#%0d", e.id), 32'(tick_a), 32'(e.tick));
    end
    if (q3.size() != 0 && q3[0].due <= cyc) begin
      e = q3.pop_front();
      chk($sformatf("rgb#%0d", e.id), 32'({r_a, g_a, b_a}), 32'({e.rgb, e.rgb, e.rgb}));
    end
  end

  task automatic px(input int xi, input int yi, input logic de, input logic ke,
                    input logic ca, input int ea, input logic et, input logic [7:0] er);
    exp_t e;
    @(posedge clk); #1;
    x = 10'(xi);
    y = 9'(yi);
    display_enabled = de;
    key_en = ke;
    vec_id++;
    e.id   = vec_id;
    e.ca   = ca;
    e.addr = 18'(ea);
    e.tick = et;
    e.rgb  = er;
    e.due  = cyc + 1;
    q1.push_back(e);
    e.due  = cyc + 3;
    q3.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) px(0, 0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q3.size() != 0) && n < 10) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(q1.size() + q3.size()), 32'd0);
  endtask

  task automatic chk_a(input int ex, input int ey, input sprite_state_t es);
    chk("a_pos_x", 32'(dut.u_motion.pos_x_q), 32'(ex));
    chk("a_pos_y", 32'(dut.u_motion.pos_y_q), 32'(ey));
    chk("a_state", 32'(dut.u_motion.state_q), 32'(es));
  endtask

  initial begin
    int   ex5 [11] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0, 1};
    logic en5 [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0};

    rst = 1'b1; display_enabled = 1'b0; x = '0; y = '0; key_en = 1'b1;
    move_en_a = 1'b0; move_en_4 = 1'b0; move_en_5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", 32'(addr_a), 32'd0);
    chk("rst_rgb", 32'({r_a, g_a, b_a}), 32'd0);
    chk("rst_tick", 32'(tick_a), 32'd0);
    chk_a(50, 50, FROZEN);
    chk("rst_dir", 32'({dut.u_motion.dir_x_neg_q, dut.u_motion.dir_y_neg_q}), 32'd0);
    chk("rst_cnt", 32'(dut.u_motion.cnt_q), 32'd0);
    chk("rst_d4", 32'({addr_4, r_4, g_4, b_4, tick_4}), 32'd0);
    chk("rst_d5", 32'({addr_5, r_5, g_5, b_5, tick_5}), 32'd0);
    chk("rst_d4_pos", 32'(dut4.u_motion.pos_x_q), 32'd438);
    rst = 1'b0;

    // Hit window, addressing, keying and blanking, issued back to back.
    px( 50,  50, 1, 1, 1,     0, 0, 8'h3C);
    px(249, 279, 1, 1, 1, 45999, 0, 8'h93);
    px(250,  50, 1, 1, 1,     0, 0, 8'h20);
    px( 49,  50, 1, 1, 1,     0, 0, 8'h20);
    px( 50, 280, 1, 1, 1,     0, 0, 8'h20);
    px(249,  50, 1, 1, 1,   199, 0, 8'hFB);
    px(100, 100, 0, 1, 0,     0, 0, 8'h00);
    px( 50,  55, 1, 1, 1,  1000, 0, 8'h20);
    px( 50,  55, 1, 0, 1,  1000, 0, 8'h00);
    px( 51,  55, 1, 1, 1,  1001, 0, 8'hA5);
    px(639, 479, 0, 1, 1,     0, 0, 8'h00);
    px(639, 479, 1, 1, 1,     0, 1, 8'h20);
    idle(3);
    chk_a(50, 50, FROZEN);

    // Motion: MOVING entered on the first tick, one pixel per tick.
    move_en_a = 1'b1;
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2); chk_a(51, 51, MOVING);
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2); chk_a(52, 52, MOVING);
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2); chk_a(53, 53, MOVING);
    px( 53,  53, 1, 1, 1,     0, 0, 8'h3C);
    px( 52,  53, 1, 1, 1,     0, 0, 8'h20);
    px(252, 282, 1, 1, 1, 45999, 0, 8'h93);

    // move_en dropped mid-frame only takes effect at the tick.
    move_en_a = 1'b0;
    idle(3); chk_a(53, 53, MOVING);
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2); chk_a(53, 53, FROZEN);
    move_en_a = 1'b1;
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2); chk_a(54, 54, MOVING);

    // Reset mid-frame with the sprite moving.
    drain();
    @(posedge clk); #1;
    rst = 1'b1; x = 10'd54; y = 9'd54; display_enabled = 1'b1; key_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    move_en_a = 1'b0;
    chk_a(50, 50, FROZEN);
    chk("mid_rst_rgb0", 32'({r_a, g_a, b_a}), 32'd0);
    chk("mid_rst_addr0", 32'(addr_a), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_addr1", 32'(addr_a), 32'd804);
    chk("mid_rst_rgb1", 32'({r_a, g_a, b_a}), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_rgb2", 32'({r_a, g_a, b_a}), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_rgb3", 32'({r_a, g_a, b_a}), 32'h181818);

    // Right-wall clamp with STEP=4.
    move_en_4 = 1'b1;
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2);
    chk("d4_x1", 32'(dut4.u_motion.pos_x_q), 32'd440);
    chk("d4_y1", 32'(dut4.u_motion.pos_y_q), 32'd54);
    chk("d4_dx1", 32'(dut4.u_motion.dir_x_neg_q), 32'd1);
    px(639, 479, 1, 1, 1, 0, 1, 8'h20); idle(2);
    chk("d4_x2", 32'(dut4.u_motion.pos_x_q), 32'd436);
    chk("d4_y2", 32'(dut4.u_motion.pos_y_q), 32'd58);
    chk("d4_dx2", 32'(dut4.u_motion.dir_x_neg_q), 32'd1);
    move_en_4 = 1'b0;

    // Small screen: bounce off the far corner, return and reverse at the origin corner.
    move_en_5 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      px(7, 5, 1, 1, 1, 0, 0, 8'h20);
      idle(2);
      chk($sformatf("d5_x%0d", k), 32'(dut5.u_motion.pos_x_q), 32'(ex5[k]));
      chk($sformatf("d5_y%0d", k), 32'(dut5.u_motion.pos_y_q), 32'(ex5[k]));
      chk($sformatf("d5_dir%0d", k),
          32'({dut5.u_motion.dir_x_neg_q, dut5.u_motion.dir_y_neg_q}),
          32'({en5[k], en5[k]}));
    end
    move_en_5 = 1'b0;

    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
